// File: rtl/float_pkg.sv
// Shared constants for the float-to-int streaming converter: rounding-mode codes,
// flag bit positions and the IEEE-style exponent bias helper.
package float_pkg;

  localparam logic [1:0] ROUND_TRUNC     = 2'd0;
  localparam logic [1:0] ROUND_NEAR_AWAY = 2'd1;
  localparam logic [1:0] ROUND_NEAR_EVEN = 2'd2;
  localparam logic [1:0] ROUND_FLOOR     = 2'd3;

  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INVALID  = 2;

  function automatic int exp_bias(input int exp_size);
    return (1 << (exp_size - 1)) - 1;
  endfunction

endpackage

// File: rtl/float_to_int_stream_if.sv
// Valid/ready stream bundle for float_to_int_stream: float words in, integers plus
// {invalid, overflow, inexact} flags out. The converter is the slave side.
interface float_to_int_stream_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   in_data;
  logic signed [EXPONENT_SIZE-1:0]        in_offset;
  logic [1:0]                             in_round;
  logic                                   in_signed;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [INT_SIZE-1:0]                    out_data;
  logic [2:0]                             out_flags;

  modport master (
    output in_valid, in_data, in_offset, in_round, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_offset, in_round, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/float_pipe_stage.sv
// One valid/ready register slice; accepts whenever empty or being drained, so a full
// chain of these runs at one word per clock with no bubbles.
module float_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/float_to_int_stream.sv
// Two-stage float-to-integer converter with valid/ready flow control.
// Define FLOAT_TO_INT_SATURATE_EN to clamp overflows; otherwise they yield 0.
module float_to_int_stream
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
) (
  input logic                  clk,
  input logic                  resetn,
  float_to_int_stream_if.slave bus
);
  localparam int MS   = MANTISSA_SIZE;
  localparam int ES   = EXPONENT_SIZE;
  localparam int I    = INT_SIZE;
  localparam int EW   = ES + 2;
  localparam int F    = I + 1;
  localparam int TW   = MS + 1 + F;
  localparam int PADW = I - MS - 1;
  localparam int S1W  = I + 10;
  localparam int S2W  = I + 3;
  localparam logic signed [EW-1:0] BIAS_S = EW'(exp_bias(ES));
  localparam logic [I:0]   POS_LIM  = {2'b00, {(I-1){1'b1}}};
  localparam logic [I:0]   NEG_LIM  = {2'b01, {(I-1){1'b0}}};
  localparam logic [I-1:0] SAT_SMAX = {1'b0, {(I-1){1'b1}}};
  localparam logic [I-1:0] SAT_SMIN = {1'b1, {(I-1){1'b0}}};
  localparam logic [I-1:0] SAT_UMAX = {I{1'b1}};

  // Stage 1: unpack, effective exponent, alignment shift with guard/sticky
  logic                 s1_sign, is_zero, is_nan, is_inf, huge, guard, sticky;
  logic [ES-1:0]        exp_f;
  logic [MS-1:0]        man_f;
  logic [MS:0]          sig;
  logic signed [EW-1:0] off_ext, e_s;
  logic signed [31:0]   e32;
  logic [31:0]          sh_l, sh_r;
  logic [TW-1:0]        tmp;
  logic [I-1:0]         mag;

  always_comb begin
    s1_sign = bus.in_data[MS+ES];
    exp_f   = bus.in_data[MS+ES-1:MS];
    man_f   = bus.in_data[MS-1:0];
    sig     = {1'b1, man_f};
    off_ext = {{2{bus.in_offset[ES-1]}}, bus.in_offset};
    e_s     = $signed({2'b00, exp_f}) - BIAS_S - off_ext;
    e32     = {{(32-EW){e_s[EW-1]}}, e_s};
    sh_l    = 32'(e32 - MS);
    sh_r    = 32'(MS - e32);
    tmp     = {sig, {F{1'b0}}} >> sh_r;
    mag     = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    if (e32 >= MS) begin
      mag = {{PADW{1'b0}}, sig} << sh_l;
    end else if (sh_r > 32'(I)) begin
      sticky = 1'b1;
    end else begin
      mag    = {{PADW{1'b0}}, tmp[TW-1:F]};
      guard  = tmp[F-1];
      sticky = |tmp[F-2:0];
    end
    is_zero = (exp_f == '0);
    is_nan  = (&exp_f) && (man_f != '0);
    is_inf  = (&exp_f) && (man_f == '0);
    huge    = (e32 >= I);
    // Denormals are flushed; only their nonzero mantissa survives, as inexact.
    if (is_zero) begin
      mag    = '0;
      guard  = 1'b0;
      sticky = |man_f;
    end
  end

  logic [S1W-1:0] s1_in, p1;
  logic           p1_valid, s2_in_ready;
  assign s1_in = {bus.in_round, bus.in_signed, s1_sign, is_zero, is_nan, is_inf,
                  huge, guard, sticky, mag};

  float_pipe_stage #(.WIDTH(S1W)) u_stage1 (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (s1_in),
    .out_valid(p1_valid),
    .out_ready(s2_in_ready),
    .out_data (p1)
  );

  // Stage 2: round, range check, negate or saturate
  logic [1:0]   p1_round;
  logic         p1_signed, p1_sign, p1_zero, p1_nan, p1_inf, p1_huge, p1_guard, p1_sticky;
  logic [I-1:0] p1_mag, sat_data, res_data;
  logic         inc, range_ovf, ovf;
  logic [I:0]   rmag;
  logic [2:0]   res_flags;

  assign {p1_round, p1_signed, p1_sign, p1_zero, p1_nan, p1_inf, p1_huge,
          p1_guard, p1_sticky, p1_mag} = p1;

  always_comb begin
    inc = 1'b0;
    case (p1_round)
      ROUND_TRUNC:     inc = 1'b0;
      ROUND_NEAR_AWAY: inc = p1_guard;
      ROUND_NEAR_EVEN: inc = p1_guard && (p1_sticky || p1_mag[0]);
      default:         inc = (p1_guard || p1_sticky) && p1_sign;
    endcase
    rmag = {1'b0, p1_mag} + {{I{1'b0}}, inc};
    if (p1_signed) range_ovf = p1_sign ? (rmag > NEG_LIM) : (rmag > POS_LIM);
    else           range_ovf = rmag[I] || (p1_sign && (rmag != '0));
    ovf = p1_inf || p1_huge || range_ovf;
`ifdef FLOAT_TO_INT_SATURATE_EN
    if (p1_signed) sat_data = p1_sign ? SAT_SMIN : SAT_SMAX;
    else           sat_data = p1_sign ? '0 : SAT_UMAX;
`else
    sat_data = '0;
`endif
    res_data  = '0;
    res_flags = '0;
    if (p1_nan) begin
      res_flags[FLAG_INVALID] = 1'b1;
    end else if (p1_zero) begin
      res_flags[FLAG_INEXACT] = p1_sticky;
    end else if (ovf) begin
      res_flags[FLAG_OVERFLOW] = 1'b1;
      res_data                 = sat_data;
    end else begin
      res_data = (p1_sign && p1_signed) ? -rmag[I-1:0] : rmag[I-1:0];
      res_flags[FLAG_INEXACT] = p1_guard || p1_sticky;
    end
  end

  logic [S2W-1:0] p2;

  float_pipe_stage #(.WIDTH(S2W)) u_stage2 (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (p1_valid),
    .in_ready (s2_in_ready),
    .in_data  ({res_flags, res_data}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (p2)
  );

  assign bus.out_data  = p2[I-1:0];
  assign bus.out_flags = p2[I+2:I];
endmodule

// File: tb/tb_float_to_int_stream.sv
// Directed bench for float_to_int_stream: conversion vectors, stalled streaming and
// mid-flight reset. Expected overflow data follows FLOAT_TO_INT_SATURATE_EN.
module tb_float_to_int_stream;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  float_to_int_stream_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) bus ();

  float_to_int_stream #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

`ifdef FLOAT_TO_INT_SATURATE_EN
  localparam logic [31:0] SAT_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG  = 32'h8000_0000;
  localparam logic [31:0] SAT_UMAX = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SAT_POS  = 32'h0;
  localparam logic [31:0] SAT_NEG  = 32'h0;
  localparam logic [31:0] SAT_UMAX = 32'h0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Single conversion on an empty pipeline: accept, then result exactly 2 edges later.
  task automatic convert(input string tag, input logic [31:0] f, input logic [7:0] off,
                         input logic [1:0] rnd, input logic sgn,
                         input logic [31:0] ed, input logic [2:0] ef);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = f;
    bus.in_offset = off;
    bus.in_round  = rnd;
    bus.in_signed = sgn;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_flags"}, {29'd0, bus.out_flags}, {29'd0, ef});
  endtask

  logic [31:0] stream_vec [8];
  int          tx, rx;
  logic        held, go;
  logic [31:0] held_data;

  initial begin
    stream_vec[0] = 32'h3F80_0000; stream_vec[1] = 32'h4000_0000;
    stream_vec[2] = 32'h4040_0000; stream_vec[3] = 32'h4080_0000;
    stream_vec[4] = 32'h40A0_0000; stream_vec[5] = 32'h40C0_0000;
    stream_vec[6] = 32'h40E0_0000; stream_vec[7] = 32'h4100_0000;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_offset = '0;
    bus.in_round = 2'd0; bus.in_signed = 1'b1; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_flags", {29'd0, bus.out_flags}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    convert("p2_5_trunc",  32'h4020_0000, 8'h00, 2'd0, 1'b1, 32'd2, 3'b001);
    convert("p2_5_away",   32'h4020_0000, 8'h00, 2'd1, 1'b1, 32'd3, 3'b001);
    convert("p2_5_even",   32'h4020_0000, 8'h00, 2'd2, 1'b1, 32'd2, 3'b001);
    convert("n2_5_floor",  32'hC020_0000, 8'h00, 2'd3, 1'b1, 32'hFFFF_FFFD, 3'b001);
    convert("n2_5_trunc",  32'hC020_0000, 8'h00, 2'd0, 1'b1, 32'hFFFF_FFFE, 3'b001);
    convert("p0_5_offm1",  32'h3F00_0000, 8'hFF, 2'd0, 1'b1, 32'd1, 3'b000);
    convert("p8_offp3",    32'h4100_0000, 8'h03, 2'd0, 1'b1, 32'd1, 3'b000);
    convert("p1_5_even",   32'h3FC0_0000, 8'h00, 2'd2, 1'b1, 32'd2, 3'b001);
    convert("p0_75_away",  32'h3F40_0000, 8'h00, 2'd1, 1'b1, 32'd1, 3'b001);
    convert("p0_75_even",  32'h3F40_0000, 8'h00, 2'd2, 1'b1, 32'd1, 3'b001);
    convert("p2p31_s",     32'h4F00_0000, 8'h00, 2'd0, 1'b1, SAT_POS, 3'b010);
    convert("p2p31_u",     32'h4F00_0000, 8'h00, 2'd0, 1'b0, 32'h8000_0000, 3'b000);
    convert("n2p31_s",     32'hCF00_0000, 8'h00, 2'd0, 1'b1, 32'h8000_0000, 3'b000);
    convert("n2p31_big_s", 32'hCF00_0001, 8'h00, 2'd0, 1'b1, SAT_NEG, 3'b010);
    convert("nan",         32'h7FC0_0000, 8'h00, 2'd0, 1'b1, 32'd0, 3'b100);
    convert("ninf_s",      32'hFF80_0000, 8'h00, 2'd0, 1'b1, SAT_NEG, 3'b010);
    convert("ndenorm_flr", 32'h8000_0001, 8'h00, 2'd3, 1'b1, 32'd0, 3'b001);
    convert("n2_5_u",      32'hC020_0000, 8'h00, 2'd0, 1'b0, 32'd0, 3'b010);
    convert("n0_25_u",     32'hBE80_0000, 8'h00, 2'd0, 1'b0, 32'd0, 3'b001);
    convert("umax_exact",  32'h4F7F_FFFF, 8'h00, 2'd0, 1'b0, 32'hFFFF_FF00, 3'b000);
    convert("p2p32_u",     32'h4F80_0000, 8'h00, 2'd0, 1'b0, SAT_UMAX, 3'b010);
    convert("p2p64_u",     32'h5F80_0000, 8'h00, 2'd0, 1'b0, SAT_UMAX, 3'b010);
    convert("tiny_away",   32'h0080_0000, 8'h00, 2'd1, 1'b1, 32'd0, 3'b001);

    // Back-to-back stream with out_ready toggling 1,0,1,0...
    tx = 0; rx = 0; held = 1'b0; held_data = '0;
    bus.in_offset = '0; bus.in_round = 2'd0; bus.in_signed = 1'b1;
    for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc % 2 == 0);
      bus.in_valid  = (tx < 8);
      if (tx < 8) bus.in_data = stream_vec[tx];
      #1;
      if (held) begin
        check("stream_stall_hold", bus.out_data, held_data);
        held = 1'b0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check($sformatf("stream_data_%0d", rx), bus.out_data, 32'(rx + 1));
          check($sformatf("stream_flags_%0d", rx), {29'd0, bus.out_flags}, 32'd0);
          rx++;
        end else begin
          held      = 1'b1;
          held_data = bus.out_data;
        end
      end
      go = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (go) tx++;
    end
    check("stream_rx_count", 32'(rx), 32'd8);
    check("stream_tx_count", 32'(tx), 32'd8);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("stream_no_dup", {31'd0, bus.out_valid}, 32'd0);

    // Reset with two words in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h4040_0000;
    @(negedge clk);
    bus.in_data   = 32'h4080_0000;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    check("inflight_valid", {31'd0, bus.out_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out_data", bus.out_data, 32'd0);
    check("midrst_out_flags", {29'd0, bus.out_flags}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("postrst_idle_%0d", k), {31'd0, bus.out_valid}, 32'd0);
    end
    convert("postrst_conv", 32'h40A0_0000, 8'h00, 2'd0, 1'b1, 32'd5, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/float_to_int_stream.md
# float_to_int_stream

Pipelined float-to-integer converter with valid/ready flow control, selectable rounding, signed/unsigned output and exception flags. It is the streaming successor of the fixed-latency float-to-int converter in the float library. It sits between float arithmetic units and integer/fixed-point consumers such as rasterizers and DACs. Throughput is one conversion per clock whenever the output is not stalled.

## Interface
- MANTISSA_SIZE, 23, stored mantissa bits
- EXPONENT_SIZE, 8, exponent bits; bias = 2^(EXPONENT_SIZE-1)-1
- INT_SIZE, 32, output width; must be ≥ MANTISSA_SIZE+2
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  1+EXPONENT_SIZE+MANTISSA_SIZE  float {sign, exponent, mantissa}
- in_offset  in  EXPONENT_SIZE signed  exponent bias shift; result scaled by 2^(-in_offset)
- in_round  in  2  0 truncate toward zero, 1 nearest ties-away, 2 nearest ties-even, 3 floor
- in_signed  in  1  1 two's-complement output, 0 unsigned output
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  INT_SIZE  converted integer
- out_flags  out  3  {invalid, overflow, inexact} for out_data

## Operation
- in_offset, in_round and in_signed are captured with in_data; they travel with the word.
- Effective exponent E = exp − (bias + in_offset), computed at EXPONENT_SIZE+2 bits signed.
- exp == 0: value is zero (denormals flushed); out_data 0, inexact = (mantissa ≠ 0).
- exp all ones, mantissa ≠ 0 (NaN): out_data 0, invalid=1.
- exp all ones, mantissa 0 (Inf): treated as overflow of the given sign.
- Otherwise significand {1, mantissa} shifted left by E−MANTISSA_SIZE or right by MANTISSA_SIZE−E; right shift keeps guard bit and sticky OR of all lower bits; shift ≥ INT_SIZE+1 leaves magnitude 0, guard 0, sticky 1.
- Rounding increments the magnitude: truncate never; ties-away on guard; ties-even on guard && (sticky || lsb); floor on (guard || sticky) && sign.
- inexact = guard || sticky (after shift), regardless of mode.
- Overflow: signed mode, magnitude > 2^(INT_SIZE−1)−1 for positive or > 2^(INT_SIZE−1) for negative; unsigned mode, magnitude > 2^INT_SIZE−1, or negative with nonzero rounded magnitude. Checked after rounding.
- Negative results in signed mode are negated; a negative result rounding to 0 gives 0 in both modes.
- Overflow result depends on configuration, flag overflow=1 in either case. invalid and overflow force inexact=0.

## Timing
- Stage 1: unpack, E, shift, guard/sticky. Stage 2: round, overflow check, negate/saturate, output register.
- Latency exactly 2 cycles from accept to out_valid with out_ready held high.
- Per stage: stage_ready = !stage_valid || next_ready; in_ready = stage-1 ready (combinational from out_ready through both stages, no bubbles).
- out_data/out_flags stable while out_valid && !out_ready.
- Simultaneous accept and consume in the same cycle on a full pipeline sustains one word/clock.
- Reset: out_valid 0, out_data 0, out_flags 0, all stage valids 0; in_ready 1 one cycle after resetn deasserts. Reset mid-operation discards in-flight words; no output produced for them.

## Configuration
- FLOAT_TO_INT_SATURATE_EN defined: overflow clamps to max (2^(INT_SIZE−1)−1 signed, 2^INT_SIZE−1 unsigned) or min (−2^(INT_SIZE−1) signed, 0 unsigned) by sign; NaN still 0.
- Undefined: overflow and Inf produce out_data 0 (legacy behaviour); flags identical.

## Structure
- float_pkg: rounding-mode localparams (ROUND_TRUNC, ROUND_NEAR_AWAY, ROUND_NEAR_EVEN, ROUND_FLOOR), flag bit indices, bias function.
- One sub-module float_pipe_stage: parametrised-width valid/ready register slice with async active-low reset, instanced twice.

## Test plan
- 0x40200000 (2.5), signed: round 0 -> 2, 1 -> 3, 2 -> 2, inexact=1 each.
- 0xC0200000 (−2.5), round 3 -> 0xFFFFFFFD (−3); round 0 -> 0xFFFFFFFE; 0x3F000000 (0.5) with offset −1 -> 1, exact.
- 0x4F000000 (2^31), signed -> 0x7FFFFFFF with macro, 0 without, overflow=1; unsigned -> 0x80000000, no flags; 0xCF000000 signed -> 0x80000000, no overflow.
- 0x7FC00000 (NaN) -> 0, invalid=1; 0xFF800000 (−Inf) signed with macro -> 0x80000000, overflow=1.
- Back-to-back 8 words with out_ready toggling 1010…: all 8 results in order, none lost or duplicated, out_data stable while stalled.
- Assert resetn low with 2 words in flight: out_valid 0 immediately, no stale outputs after release, next word converts with 2-cycle latency.
